conv33_output_stage: RTL and testbench

//  Downstream stage of the conv33 naive compute pipeline. Consumes the per-pixel 3x3 window sum produced by the output

---
 rtl/conv33_pkg.sv | 20 ++
 rtl/conv33_out_fifo.sv | 79 +++++++
 rtl/conv33_output_stage.sv | 97 +++++++++
 tb/tb_conv33_output_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv33_pkg.sv
// Shared types and helpers for the conv33 output stage.
package conv33_pkg;

  localparam int PIX_W = 16;

  typedef logic [PIX_W-1:0] pix_t;

  // One FIFO entry: the scaled window result plus its end-of-frame marker.
  typedef struct packed {
    logic last;
    pix_t data;
  } out_entry_t;

  // Bits needed to hold a raster coordinate in the range 0..n-1.
  function automatic int coord_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/conv33_out_fifo.sv
// Small synchronous FIFO of out_entry_t.
// The head is read straight from storage, so an entry pushed in one cycle
// is visible on head in the next cycle.
// Pushing into a full FIFO is accepted only when a pop happens in the same
// cycle. The new entry then lands in the slot being vacated, which is the
// logical tail.
module conv33_out_fifo
  import conv33_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  out_entry_t entry,
  output logic       full,
  input  logic       pop,
  output out_entry_t head,
  output logic       empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  out_entry_t      mem_q [DEPTH];
  out_entry_t      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNTW'(DEPTH));
  // Report zeros when empty so that nothing stale shows on the outputs.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state logic: write the tail and advance the pointers and occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNTW'(do_push) - CNTW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      // Storage slot gi.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) mem_q[gi] <= '0;
        else        mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/conv33_output_stage.sv
// conv33 output stage.
// Tracks the raster position of each accepted pixel and drops windows on the
// first two rows and columns. Valid windows are scaled and queued to a
// ready/valid stream. Overflow is recorded as a sticky flag.
module conv33_output_stage
  import conv33_pkg::*;
#(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int SHIFT      = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_last,
  output logic             frame_done,
  output logic             overflow
);

  localparam int CW = coord_w(IMG_W);
  localparam int RW = coord_w(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;

  logic          at_last_col, at_last_row, at_last;
  logic          win_valid, fifo_full, fifo_empty, pop;
  out_entry_t    push_entry, head_entry;

  assign at_last_col = (col_q == CW'(IMG_W - 1));
  assign at_last_row = (row_q == RW'(IMG_H - 1));
  assign at_last     = at_last_col & at_last_row;

  // A window is complete once at least two earlier rows and columns exist.
  assign win_valid  = in_valid & (col_q >= CW'(2)) & (row_q >= RW'(2));
  assign push_entry = '{last: at_last, data: pix_t'(sum_in >> SHIFT)};

  assign out_valid  = ~fifo_empty;
  assign out_data   = head_entry.data;
  assign out_last   = head_entry.last;
  assign pop        = out_valid & out_ready;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

  // Raster counters, end-of-frame pulse, and the sticky overflow decision.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = in_valid & at_last;
    // A full FIFO still accepts the push if the head leaves in the same cycle.
    overflow_d   = overflow_q | (win_valid & fifo_full & ~pop);
    if (in_valid) begin
      if (at_last_col) begin
        col_d = '0;
        row_d = at_last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  conv33_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (win_valid),
    .entry (push_entry),
    .full  (fifo_full),
    .pop   (pop),
    .head  (head_entry),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_conv33_output_stage.sv
// Testbench for conv33_output_stage.
// Two instances share the stimulus, one with SHIFT=0 and one with SHIFT=3.
// A queue-based reference model is checked every cycle. Hand-derived vector
// tables and directed sequences cover the corner cases.
module tb_conv33_output_stage;

  localparam int W = 4;
  localparam int H = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] sum_in = '0;
  logic        out_ready = 1'b0;

  logic        out_valid0, out_last0, frame_done0, overflow0;
  logic [15:0] out_data0;
  logic        out_valid3, out_last3, frame_done3, overflow3;
  logic [15:0] out_data3;

  always #5 clk = ~clk;

  conv33_output_stage #(.IMG_W(W), .IMG_H(H), .SHIFT(0), .FIFO_DEPTH(D)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sum_in(sum_in),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_last(out_last0), .frame_done(frame_done0), .overflow(overflow0)
  );

  conv33_output_stage #(.IMG_W(W), .IMG_H(H), .SHIFT(3), .FIFO_DEPTH(D)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sum_in(sum_in),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_last(out_last3), .frame_done(frame_done3), .overflow(overflow3)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit          last;
    logic [15:0] d0;
    logic [15:0] d3;
  } ent_t;

  ent_t mq[$];
  int   m_pix;   // index of next pixel within the frame
  bit   m_ovf;
  bit   m_fd;

  task automatic model_reset();
    mq.delete();
    m_pix = 0;
    m_ovf = 0;
    m_fd  = 0;
  endtask

  task automatic model_update(input bit v, input logic [15:0] s, input bit rdy);
    int   r, c;
    bit   pop, push;
    ent_t e;
    r    = m_pix / W;
    c    = m_pix % W;
    pop  = (mq.size() > 0) && rdy;
    push = v && (r >= 2) && (c >= 2);
    if (push && mq.size() == D && !pop) begin
      m_ovf = 1;
      push  = 0;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.last = (m_pix == W * H - 1);
      e.d0   = s;
      e.d3   = s >> 3;
      mq.push_back(e);
    end
    m_fd = v && (m_pix == W * H - 1);
    if (v) m_pix = (m_pix + 1) % (W * H);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit ev;
    ev = (mq.size() > 0);
    check("m_valid0", 32'(out_valid0), 32'(ev));
    check("m_valid3", 32'(out_valid3), 32'(ev));
    if (ev) begin
      check("m_data0", 32'(out_data0), 32'(mq[0].d0));
      check("m_data3", 32'(out_data3), 32'(mq[0].d3));
      check("m_last0", 32'(out_last0), 32'(mq[0].last));
      check("m_last3", 32'(out_last3), 32'(mq[0].last));
    end
    check("m_fd0",  32'(frame_done0), 32'(m_fd));
    check("m_fd3",  32'(frame_done3), 32'(m_fd));
    check("m_ovf0", 32'(overflow0), 32'(m_ovf));
    check("m_ovf3", 32'(overflow3), 32'(m_ovf));
  endtask

  // Drive one cycle (called at posedge+1), then sample at the next posedge+1.
  task automatic step(input bit v, input logic [15:0] s, input bit rdy);
    in_valid  = v;
    sum_in    = s;
    out_ready = rdy;
    model_update(v, s, rdy);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  // Asynchronous assertion checked before any clock edge; release after an edge.
  task automatic do_reset(input string tag);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check({tag, "_rst_valid"}, 32'(out_valid0), 32'd0);
    check({tag, "_rst_data"},  32'(out_data0), 32'd0);
    check({tag, "_rst_last"},  32'(out_last0), 32'd0);
    check({tag, "_rst_fd"},    32'(frame_done0), 32'd0);
    check({tag, "_rst_ovf"},   32'(overflow0), 32'd0);
    check({tag, "_rst_ovf3"},  32'(overflow3), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- hand-derived vectors for a full 4x4 frame ----------------
  typedef struct {
    bit          v;
    logic [15:0] s;
    bit          rdy;
    bit          ev;
    logic [15:0] ed;
    bit          el;
    bit          efd;
  } vec_t;

  vec_t tbl[17];

  task automatic run_table(input string tag);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].rdy);
      check({tag, "_valid"}, 32'(out_valid0), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        check({tag, "_data"}, 32'(out_data0), 32'(tbl[i].ed));
        check({tag, "_last"}, 32'(out_last0), 32'(tbl[i].el));
      end
      check({tag, "_fd"}, 32'(frame_done0), 32'(tbl[i].efd));
      $display("%s vec %0d: valid=%0b data=%0d last=%0b fd=%0b", tag, i,
               out_valid0, out_data0, out_last0, frame_done0);
    end
  endtask

  initial begin
    // Inside a 4x4 frame, complete windows end at pixels 10, 11, 14 and 15.
    for (int i = 0; i < 16; i++) begin
      tbl[i].v   = 1'b1;
      tbl[i].s   = 16'(i);
      tbl[i].rdy = 1'b1;
      tbl[i].ev  = (i == 10) || (i == 11) || (i == 14) || (i == 15);
      tbl[i].ed  = 16'(i);
      tbl[i].el  = (i == 15);
      tbl[i].efd = (i == 15);
    end
    tbl[16] = '{v: 1'b0, s: 16'd0, rdy: 1'b1, ev: 1'b0, ed: 16'd0, el: 1'b0, efd: 1'b0};

    do_reset("init");

    // Scenario 1: back-to-back frame.
    run_table("s1");

    // Scenario 2: one pixel on, two off.
    do_reset("s2");
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'(i), 1'b1);
      step(1'b0, 16'($urandom), 1'b1);
      step(1'b0, 16'($urandom), 1'b1);
      $display("s2 pixel %0d: valid=%0b data=%0d fd=%0b", i, out_valid0, out_data0, frame_done0);
    end

    // Scenario 3: scaling on the SHIFT=3 instance.
    do_reset("s3");
    for (int i = 0; i < 16; i++) begin
      logic [15:0] s;
      s = (i == 10) ? 16'h0048 : (i == 11) ? 16'hFFFF : 16'(i);
      step(1'b1, s, 1'b1);
      if (i == 10) check("s3_shift_48", 32'(out_data3), 32'h0009);
      if (i == 11) check("s3_shift_ffff", 32'(out_data3), 32'h1FFF);
      $display("s3 pixel %0d: data0=%0h data3=%0h", i, out_data0, out_data3);
    end

    // Scenario 4: stalled output, the fifth window is dropped.
    do_reset("s4");
    for (int i = 0; i < 27; i++) step(1'b1, 16'(i % 16), 1'b0);
    check("s4_ovf_set", 32'(overflow0), 32'd1);
    $display("s4 after stall: valid=%0b ovf=%0b", out_valid0, overflow0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'd0, 1'b1);
      $display("s4 drain %0d: valid=%0b data=%0d ovf=%0b", i, out_valid0, out_data0, overflow0);
    end
    check("s4_ovf_sticky", 32'(overflow0), 32'd1);
    check("s4_drained", 32'(out_valid0), 32'd0);

    // Scenario 5: full FIFO with push and pop in the same cycle.
    do_reset("s5");
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 16'(100 + i), 1'b0);
    step(1'b1, 16'd110, 1'b1);
    check("s5_no_ovf", 32'(overflow0), 32'd0);
    check("s5_head", 32'(out_data0), 32'd11);
    $display("s5 push+pop: head=%0d ovf=%0b", out_data0, overflow0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'd0, 1'b1);

    // Scenario 6: reset mid-frame, then a clean frame.
    do_reset("s6a");
    for (int i = 0; i < 6; i++) step(1'b1, 16'(i), 1'b1);
    do_reset("s6");
    run_table("s6");

    // Randomized traffic against the model.
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0);
      if (i % 40 == 0)
        $display("rnd cycle %0d: valid=%0b data=%0h ovf=%0b", i, out_valid0, out_data0, overflow0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
